// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register: two-entry skid buffer with valid/ready handshake,
// presenting the head instruction to decode along with its field slices.
module if_id_skid_reg #(
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm_16,
  output logic [25:0]     jaddr,
  output logic [1:0]      ext_sel
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  entry_t main_q, skid_q, in_ent;
  logic   main_valid, skid_valid;
  logic   accept, drain, main_load, skid_load;
  logic   main_valid_nxt, skid_valid_nxt;

  assign in_ent    = '{pc: in_pc, inst: in_inst};
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid & out_ready;
  assign main_load = !main_valid | drain;
  assign skid_load = accept & main_valid & !drain;

  // Skid can only be full while in_ready is low, so it never loads and
  // drains in the same cycle; flush overrides everything.
  always_comb begin
    main_valid_nxt = main_valid;
    skid_valid_nxt = skid_valid;
    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else begin
      if (main_load) begin
        main_valid_nxt = skid_valid | accept;
        skid_valid_nxt = 1'b0;
      end
      if (skid_load) skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      main_q     <= '{pc: '0, inst: NOP_INST};
      skid_q     <= '{pc: '0, inst: NOP_INST};
    end else begin
      main_valid <= main_valid_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready   <= !skid_valid_nxt;
      if (!flush && main_load) begin
        if (skid_valid)  main_q <= skid_q;
        else if (accept) main_q <= in_ent;
      end
      if (!flush && skid_load) skid_q <= in_ent;
    end
  end

  assign out_valid = main_valid;
  assign out_pc    = main_q.pc;
  assign out_inst  = main_valid ? main_q.inst : NOP_INST;

  assign opcode = out_inst[31:26];
  assign rs     = out_inst[25:21];
  assign rt     = out_inst[20:16];
  assign rd     = out_inst[15:11];
  assign shamt  = out_inst[10:6];
  assign funct  = out_inst[5:0];
  assign imm_16 = out_inst[15:0];
  assign jaddr  = out_inst[25:0];

  // Logical immediates zero-extend, lui shifts up; everything else sign-extends.
  always_comb begin
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: ext_sel = 2'b01;
      6'h0F:               ext_sel = 2'b10;
      default:             ext_sel = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed table-driven bench for if_id_skid_reg plus an async-reset-mid-stall sequence.
module tb_if_id_skid_reg;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm_16;
  logic [25:0] jaddr;
  logic [1:0]  ext_sel;

  int n_chk = 0;
  int n_fail = 0;

  if_id_skid_reg #(.PC_W(32), .NOP_INST(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm_16(imm_16), .jaddr(jaddr), .ext_sel(ext_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        erdy;
    logic [1:0]  eext;
    logic [5:0]  eop;
    logic [4:0]  ert;
    logic [15:0] eimm;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    //           iv  pc      inst           ordy fl  ev  epc     einst          erdy ext    op     rt     imm
    vecs[0]  = '{1, 32'h00, 32'h2002_0005, 1, 0, 1, 32'h00, 32'h2002_0005, 1, 2'b00, 6'h08, 5'd2,  16'h0005};
    vecs[1]  = '{1, 32'h04, 32'h3508_FFFF, 1, 0, 1, 32'h04, 32'h3508_FFFF, 1, 2'b01, 6'h0D, 5'd8,  16'hFFFF};
    vecs[2]  = '{1, 32'h08, 32'h3C01_1234, 1, 0, 1, 32'h08, 32'h3C01_1234, 1, 2'b10, 6'h0F, 5'd1,  16'h1234};
    vecs[3]  = '{0, 32'h00, 32'h0000_0000, 1, 0, 0, 32'h00, 32'h0000_0000, 1, 2'b00, 6'h00, 5'd0,  16'h0000};
    vecs[4]  = '{1, 32'h0C, 32'h2002_FFFF, 1, 0, 1, 32'h0C, 32'h2002_FFFF, 1, 2'b00, 6'h08, 5'd2,  16'hFFFF};
    vecs[5]  = '{0, 32'h00, 32'h0000_0000, 1, 0, 0, 32'h00, 32'h0000_0000, 1, 2'b00, 6'h00, 5'd0,  16'h0000};
    // backpressure: A held, B to skid, C refused, then A,B,C drain in order
    vecs[6]  = '{1, 32'h10, 32'h3C0A_AAAA, 0, 0, 1, 32'h10, 32'h3C0A_AAAA, 1, 2'b10, 6'h0F, 5'd10, 16'hAAAA};
    vecs[7]  = '{1, 32'h14, 32'h3108_0001, 0, 0, 1, 32'h10, 32'h3C0A_AAAA, 0, 2'b10, 6'h0F, 5'd10, 16'hAAAA};
    vecs[8]  = '{1, 32'h18, 32'h8D09_0004, 0, 0, 1, 32'h10, 32'h3C0A_AAAA, 0, 2'b10, 6'h0F, 5'd10, 16'hAAAA};
    vecs[9]  = '{1, 32'h18, 32'h8D09_0004, 1, 0, 1, 32'h14, 32'h3108_0001, 1, 2'b01, 6'h0C, 5'd8,  16'h0001};
    vecs[10] = '{1, 32'h18, 32'h8D09_0004, 1, 0, 1, 32'h18, 32'h8D09_0004, 1, 2'b00, 6'h23, 5'd9,  16'h0004};
    vecs[11] = '{0, 32'h00, 32'h0000_0000, 1, 0, 0, 32'h00, 32'h0000_0000, 1, 2'b00, 6'h00, 5'd0,  16'h0000};
    // flush with main+skid full and a same-cycle offer
    vecs[12] = '{1, 32'h20, 32'h2401_0001, 0, 0, 1, 32'h20, 32'h2401_0001, 1, 2'b00, 6'h09, 5'd1,  16'h0001};
    vecs[13] = '{1, 32'h24, 32'h2801_0002, 0, 0, 1, 32'h20, 32'h2401_0001, 0, 2'b00, 6'h09, 5'd1,  16'h0001};
    vecs[14] = '{1, 32'h28, 32'h3801_0003, 0, 1, 0, 32'h00, 32'h0000_0000, 1, 2'b00, 6'h00, 5'd0,  16'h0000};
    vecs[15] = '{0, 32'h00, 32'h0000_0000, 1, 0, 0, 32'h00, 32'h0000_0000, 1, 2'b00, 6'h00, 5'd0,  16'h0000};
    vecs[16] = '{1, 32'h30, 32'h2C01_0003, 1, 0, 1, 32'h30, 32'h2C01_0003, 1, 2'b00, 6'h0B, 5'd1,  16'h0003};
    vecs[17] = '{0, 32'h00, 32'h0000_0000, 1, 0, 0, 32'h00, 32'h0000_0000, 1, 2'b00, 6'h00, 5'd0,  16'h0000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_inst", out_inst, 32'h0);
    chk("reset out_pc", out_pc, 32'h0);
    chk("reset ext_sel", {30'd0, ext_sel}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid = vecs[i].iv; in_pc = vecs[i].pc; in_inst = vecs[i].inst;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].erdy});
      chk($sformatf("v%0d out_inst", i), out_inst, vecs[i].einst);
      chk($sformatf("v%0d ext_sel", i), {30'd0, ext_sel}, {30'd0, vecs[i].eext});
      chk($sformatf("v%0d opcode", i), {26'd0, opcode}, {26'd0, vecs[i].eop});
      chk($sformatf("v%0d rt", i), {27'd0, rt}, {27'd0, vecs[i].ert});
      chk($sformatf("v%0d imm_16", i), {16'd0, imm_16}, {16'd0, vecs[i].eimm});
      if (vecs[i].ev) chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].epc);
      if (i == 1) chk("v1 rs", {27'd0, rs}, 32'd8);
    end

    // Fill main and skid, then drop reset between edges
    @(negedge clk);
    in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'h3508_1111; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    in_pc = 32'h44; in_inst = 32'h3508_2222;
    @(negedge clk);
    in_valid = 1'b0;
    chk("stall out_valid", {31'd0, out_valid}, 32'd1);
    chk("stall in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall out_pc", out_pc, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", {31'd0, out_valid}, 32'd0);
    chk("async in_ready", {31'd0, in_ready}, 32'd1);
    chk("async out_inst", out_inst, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset out_valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
